// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Channel state encoding, retry counter width and counter width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_STANDBY,
    ST_FAULT
  } pll_seq_state_t;

  localparam int unsigned RETRY_W = 4;

  // One counter serves both the reset pulse and the lock timeout, so it
  // must hold the larger of the two thresholds.
  function automatic int unsigned cnt_width(input int unsigned reset_cycles,
                                            input int unsigned timeout_cycles);
    int unsigned m;
    m = (reset_cycles > timeout_cycles) ? reset_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_chan_seq.sv
// One PLL channel: LOCK synchroniser, bring-up FSM, dwell counters and retry count.
// Outputs are registered from the next state so they change on the transition edge.
module pll_chan_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               stdby_req,
  input  logic               lock,
  output logic               pllreset,
  output logic               stdby,
  output logic               ready,
  output logic               fault,
  output logic               loss_evt,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  pll_seq_state_t state, state_nxt;
  logic               lock_meta, lk;
  logic [CW-1:0]      tmo_cnt, stb_cnt;
  logic [RETRY_W-1:0] retry_inc;
  logic               pllreset_d, stdby_d, ready_d, fault_d, loss_d;
  logic [RETRY_W-1:0] retry_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lk        <= 1'b0;
      state     <= ST_OFF;
      tmo_cnt   <= '0;
      stb_cnt   <= '0;
      pllreset  <= 1'b1;
      stdby     <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      loss_evt  <= 1'b0;
      retry_cnt <= '0;
    end else begin
      lock_meta <= lock;
      lk        <= lock_meta;
      state     <= state_nxt;
      // Counters restart on every state change and only run in RESET/WAIT_LOCK.
      if (state_nxt != state) begin
        tmo_cnt <= '0;
        stb_cnt <= '0;
      end else begin
        unique case (state)
          ST_RESET: begin
            tmo_cnt <= sat_inc(tmo_cnt);
            stb_cnt <= '0;
          end
          ST_WAIT_LOCK: begin
            tmo_cnt <= sat_inc(tmo_cnt);
            stb_cnt <= lk ? sat_inc(stb_cnt) : '0;
          end
          default: begin
            tmo_cnt <= '0;
            stb_cnt <= '0;
          end
        endcase
      end
      pllreset  <= pllreset_d;
      stdby     <= stdby_d;
      ready     <= ready_d;
      fault     <= fault_d;
      loss_evt  <= loss_d;
      retry_cnt <= retry_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:       state_nxt = ST_RESET;
      ST_RESET:     if (tmo_cnt >= RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lk && (stb_cnt >= STB_LAST))
          state_nxt = ST_LOCKED;
        else if (tmo_cnt >= TMO_LAST)
          state_nxt = (retry_inc >= RETRY_MAX) ? ST_FAULT : ST_RESET;
      end
      ST_LOCKED: begin
        if (stdby_req)
          state_nxt = ST_STANDBY;
        else if (!lk)
          state_nxt = ST_RESET;
      end
      ST_STANDBY:   if (!stdby_req) state_nxt = ST_WAIT_LOCK;
      ST_FAULT:     state_nxt = ST_FAULT;
      default:      state_nxt = ST_OFF;
    endcase
    if (!en)
      state_nxt = ST_OFF;
  end

  always_comb begin
    pllreset_d = (state_nxt == ST_OFF) || (state_nxt == ST_RESET) ||
                 (state_nxt == ST_FAULT);
    stdby_d    = (state_nxt == ST_STANDBY);
    ready_d    = (state_nxt == ST_LOCKED);
    fault_d    = (state_nxt == ST_FAULT);
    loss_d     = (state == ST_LOCKED) && en && !stdby_req && !lk;
    retry_d    = retry_cnt;
    if (state_nxt == ST_OFF)
      retry_d = '0;
    else if (state == ST_WAIT_LOCK && state_nxt == ST_LOCKED)
      retry_d = '0;
    else if (state == ST_WAIT_LOCK &&
             (state_nxt == ST_RESET || state_nxt == ST_FAULT))
      retry_d = retry_inc;
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Multi-channel PLL_CORE supervisor: one pll_chan_seq per PLL plus the
// registered ALL_READY reduction over enabled channels.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned N_PLL               = 2,
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_PLL-1:0]           EN,
  input  logic [N_PLL-1:0]           STDBY_REQ,
  input  logic [N_PLL-1:0]           LOCK,
  output logic [N_PLL-1:0]           PLLRESET,
  output logic [N_PLL-1:0]           STDBY,
  output logic [N_PLL-1:0]           READY,
  output logic [N_PLL-1:0]           FAULT,
  output logic [N_PLL-1:0]           LOSS_EVT,
  output logic [RETRY_W*N_PLL-1:0]   RETRY_CNT,
  output logic                       ALL_READY
);

  for (genvar g = 0; g < N_PLL; g++) begin : g_chan
    pll_chan_seq #(
      .RESET_CYCLES        (RESET_CYCLES),
      .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
      .MAX_RETRIES         (MAX_RETRIES)
    ) u_chan (
      .clk       (CLK),
      .rst       (RST),
      .en        (EN[g]),
      .stdby_req (STDBY_REQ[g]),
      .lock      (LOCK[g]),
      .pllreset  (PLLRESET[g]),
      .stdby     (STDBY[g]),
      .ready     (READY[g]),
      .fault     (FAULT[g]),
      .loss_evt  (LOSS_EVT[g]),
      .retry_cnt (RETRY_CNT[RETRY_W*g +: RETRY_W])
    );
  end

  // Disabled channels are masked out; no enabled channel means not ready.
  always_ff @(posedge CLK) begin
    if (RST)
      ALL_READY <= 1'b0;
    else
      ALL_READY <= (|EN) && (&(READY | ~EN));
  end

endmodule
